// File: rtl/day_month_counter.sv
// Calendar day/month counter: advances on the midnight tick, with a
// month-then-day set mode. Define LEAP_YEAR_EN to honour leap_year in February.
module day_month_counter #(
  parameter int INIT_DAY   = 1,
  parameter int INIT_MONTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       day_tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       leap_year,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic       year_tick,
  output logic [1:0] set_mode
);

  localparam logic [1:0] ST_RUN       = 2'b00;
  localparam logic [1:0] ST_SET_MONTH = 2'b01;
  localparam logic [1:0] ST_SET_DAY   = 2'b10;

  function automatic logic [4:0] dim_of(input logic [3:0] m, input logic leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: dim_of = 5'd30;
      4'd2:                    dim_of = leap ? 5'd29 : 5'd28;
      default:                 dim_of = 5'd31;
    endcase
  endfunction

  function automatic int max_dim(input int m);
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
`ifdef LEAP_YEAR_EN
    if (m == 2) return 29;
`else
    if (m == 2) return 28;
`endif
    return 31;
  endfunction

  if (INIT_MONTH < 1 || INIT_MONTH > 12 ||
      INIT_DAY < 1 || INIT_DAY > max_dim(INIT_MONTH)) begin : g_bad_init
    $error("day_month_counter: INIT_DAY/INIT_MONTH out of range");
  end

  logic       w_leap;
`ifdef LEAP_YEAR_EN
  assign w_leap = leap_year;
`else
  logic w_unused_leap;
  assign w_leap        = 1'b0;
  assign w_unused_leap = leap_year;
`endif

  logic [1:0] r_state;
  logic [4:0] r_day;
  logic [3:0] r_month;
  logic       r_year_tick;

  logic [1:0] w_state_nx;
  logic [4:0] w_day_nx;
  logic [3:0] w_month_nx;
  logic       w_year_tick_nx;
  logic [4:0] w_dim;
  logic [3:0] w_month_inc;
  logic [4:0] w_dim_inc;

  assign w_dim       = dim_of(r_month, w_leap);
  assign w_month_inc = (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;
  assign w_dim_inc   = dim_of(w_month_inc, w_leap);

  // >= rather than == so a stale Feb 29 rolls over once leap_year drops
  always_comb begin
    w_state_nx     = r_state;
    w_day_nx       = r_day;
    w_month_nx     = r_month;
    w_year_tick_nx = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (mode_btn) w_state_nx = ST_SET_MONTH;
        if (day_tick) begin
          if (r_day >= w_dim) begin
            w_day_nx = 5'd1;
            if (r_month == 4'd12) begin
              w_month_nx     = 4'd1;
              w_year_tick_nx = 1'b1;
            end else begin
              w_month_nx = r_month + 4'd1;
            end
          end else begin
            w_day_nx = r_day + 5'd1;
          end
        end
      end
      ST_SET_MONTH: begin
        if (mode_btn) begin
          w_state_nx = ST_SET_DAY;
        end else if (inc_btn) begin
          w_month_nx = w_month_inc;
          if (r_day > w_dim_inc) w_day_nx = w_dim_inc;
        end
      end
      ST_SET_DAY: begin
        if (mode_btn) begin
          w_state_nx = ST_RUN;
        end else if (inc_btn) begin
          w_day_nx = (r_day >= w_dim) ? 5'd1 : r_day + 5'd1;
        end
      end
      default: w_state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_day       <= 5'(INIT_DAY);
      r_month     <= 4'(INIT_MONTH);
      r_year_tick <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_day       <= w_day_nx;
      r_month     <= w_month_nx;
      r_year_tick <= w_year_tick_nx;
    end
  end

  assign day       = r_day;
  assign month     = r_month;
  assign year_tick = r_year_tick;
  assign set_mode  = r_state;

endmodule

// File: tb/tb_day_month_counter.sv
// Directed bench for day_month_counter; expectations follow LEAP_YEAR_EN if defined.
module tb_day_month_counter;

  logic       clk;
  logic       rst;
  logic       day_tick;
  logic       mode_btn;
  logic       inc_btn;
  logic       leap_year;
  logic [4:0] day;
  logic [3:0] month;
  logic       year_tick;
  logic [1:0] set_mode;

  int n_tests = 0;
  int n_fail  = 0;

  day_month_counter #(.INIT_DAY(1), .INIT_MONTH(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .day_tick  (day_tick),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .leap_year (leap_year),
    .day       (day),
    .month     (month),
    .year_tick (year_tick),
    .set_mode  (set_mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_date(input string tag, input int d, input int m, input int sm);
    chk({tag, ".day"}, int'(day), d);
    chk({tag, ".month"}, int'(month), m);
    chk({tag, ".set_mode"}, int'(set_mode), sm);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic press(input logic dt, input logic mb, input logic ib);
    day_tick = dt;
    mode_btn = mb;
    inc_btn  = ib;
    @(posedge clk);
    #1;
    day_tick = 1'b0;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
  endtask

  task automatic incs(input int n);
    repeat (n) press(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; day_tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0; leap_year = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_date("reset", 1, 1, 0);
    chk("reset.year_tick", int'(year_tick), 0);
    rst = 1'b0;

    // 10 midnight ticks from 1/1
    press(1'b1, 1'b0, 1'b0);
    chk_date("tick1", 2, 1, 0);
    repeat (9) press(1'b1, 1'b0, 1'b0);
    chk_date("tick10", 11, 1, 0);
    chk("tick10.year_tick", int'(year_tick), 0);

    // Set 12/31 and roll the year
    press(1'b0, 1'b1, 1'b0);
    chk("enter_set_month", int'(set_mode), 1);
    incs(11);
    chk_date("month12", 11, 12, 1);
    press(1'b0, 1'b1, 1'b0);
    chk("enter_set_day", int'(set_mode), 2);
    incs(20);
    press(1'b0, 1'b1, 1'b0);
    chk_date("dec31", 31, 12, 0);
    press(1'b1, 1'b0, 1'b0);
    chk_date("newyear", 1, 1, 0);
    chk("newyear.year_tick", int'(year_tick), 1);
    press(1'b0, 1'b0, 1'b0);
    chk("newyear+1.year_tick", int'(year_tick), 0);

    // 2/28 with leap_year=1
    press(1'b0, 1'b1, 1'b0);
    incs(1);
    press(1'b0, 1'b1, 1'b0);
    incs(27);
    press(1'b0, 1'b1, 1'b0);
    chk_date("feb28", 28, 2, 0);
    leap_year = 1'b1;
    press(1'b1, 1'b0, 1'b0);
`ifdef LEAP_YEAR_EN
    chk_date("leap.feb29", 29, 2, 0);
    leap_year = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    chk_date("feb29_selfcorrect", 1, 3, 0);
`else
    chk_date("noleap.mar1", 1, 3, 0);
`endif
    leap_year = 1'b0;

    // Day wrap in SET_DAY and clamping in SET_MONTH
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    incs(30);
    chk_date("mar31", 31, 3, 2);
    incs(1);
    chk_date("setday_wrap", 1, 3, 2);
    incs(30);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    incs(1);
    chk_date("apr_clamp", 30, 4, 1);
    incs(1);
    chk_date("may_keep30", 30, 5, 1);
    incs(8);
    chk_date("month_wrap_jan", 30, 1, 1);
    press(1'b0, 1'b1, 1'b0);
    incs(1);
    chk_date("jan31", 31, 1, 2);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    incs(1);
    chk_date("feb_clamp", 28, 2, 1);

    // Frozen date while setting, button priority, simultaneous mode+tick
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk_date("setday_tick_ignored", 28, 2, 2);
    press(1'b0, 1'b1, 1'b1);
    chk_date("mode_beats_inc", 28, 2, 0);
    press(1'b1, 1'b1, 1'b0);
    chk_date("mode_and_tick", 1, 3, 1);
    chk("mode_and_tick.year_tick", int'(year_tick), 0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk_date("first_run_tick", 2, 3, 0);

    // Asynchronous reset between edges while in SET_MONTH
    press(1'b0, 1'b1, 1'b0);
    chk("pre_reset.set_mode", int'(set_mode), 1);
    #2 rst = 1'b1;
    #1;
    chk_date("async_reset", 1, 1, 0);
    chk("async_reset.year_tick", int'(year_tick), 0);
    day_tick = 1'b1;
    mode_btn = 1'b1;
    @(posedge clk);
    #1;
    day_tick = 1'b0;
    mode_btn = 1'b0;
    chk_date("reset_held", 1, 1, 0);
    rst = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    chk_date("after_reset_tick", 2, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
